// File: rtl/obs_pkg.sv
// obs_pkg: shared widths and enums for the OBS operand split/dispatch front end
package obs_pkg;
  localparam int N_OBS = 52;
  localparam int H_OBS = N_OBS / 2;
  typedef enum logic [1:0] {IDX_EE, IDX_EO, IDX_OE, IDX_OO} sub_idx_e;
  typedef enum logic {S_IDLE, S_ISSUE} state_e;
endpackage

// File: rtl/obs_deinterleave.sv
// obs_deinterleave: split an N-bit GF(2) polynomial into even/odd coefficient halves
//   d_i    [N_OBS-1:0]  polynomial, bit i = coefficient of x^i
//   even_o [H_OBS-1:0]  even_o[i] = d_i[2i]
//   odd_o  [H_OBS-1:0]  odd_o[i]  = d_i[2i+1]
module obs_deinterleave
  import obs_pkg::*;
(
  input  logic [N_OBS-1:0] d_i,
  output logic [H_OBS-1:0] even_o,
  output logic [H_OBS-1:0] odd_o
);
  for (genvar i = 0; i < H_OBS; i++) begin : g_split
    assign even_o[i] = d_i[2*i];
    assign odd_o[i]  = d_i[2*i+1];
  end
endmodule

// File: rtl/obs_split_dispatch_52bit.sv
// obs_split_dispatch_52bit: split operand pair into even/odd halves, issue 4 sub-products per op
//   in_valid/in_ready, a_in, b_in     : operand pair handshake (N_OBS bits each)
//   sub_valid/sub_ready               : beat handshake to shared sub-multiplier
//   sub_a, sub_b, sub_idx, sub_last   : registered beat payload (idx 0..3: EE, EO, OE, OO)
//   busy                              : operation active or buffered
//   OBS_SPLIT_PREFETCH_EN             : adds a one-entry prefetch buffer (4-cycle throughput)
module obs_split_dispatch_52bit
  import obs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_OBS-1:0] a_in,
  input  logic [N_OBS-1:0] b_in,
  output logic             sub_valid,
  input  logic             sub_ready,
  output logic [H_OBS-1:0] sub_a,
  output logic [H_OBS-1:0] sub_b,
  output logic [1:0]       sub_idx,
  output logic             sub_last,
  output logic             busy
);
  logic [H_OBS-1:0] a_e, a_o, b_e, b_o;
  obs_deinterleave u_da (.d_i(a_in), .even_o(a_e), .odd_o(a_o));
  obs_deinterleave u_db (.d_i(b_in), .even_o(b_e), .odd_o(b_o));
  state_e state_q, state_d;
  logic [4*H_OBS-1:0] split, src, act_q, act_d;
  logic [H_OBS-1:0] cur_ae, cur_ao, cur_be, cur_bo;
  logic [H_OBS-1:0] sub_a_q, sub_a_d, sub_b_q, sub_b_d;
  logic [1:0] sub_idx_q, sub_idx_d;
  logic sub_valid_q, sub_valid_d, sub_last_q, sub_last_d;
  logic accept, fire, last_fire, load;
  assign split     = {a_e, a_o, b_e, b_o};
  assign accept    = in_valid && in_ready;
  assign fire      = sub_valid_q && sub_ready;
  assign last_fire = fire && sub_idx_q == IDX_OO;
`ifdef OBS_SPLIT_PREFETCH_EN
  logic buf_full_q, buf_full_d;
  logic [4*H_OBS-1:0] buf_q;
  assign in_ready = !buf_full_q;
  // a new op starts from idle, or on the last beat from the buffer / a same-cycle arrival
  assign load       = (state_q == S_IDLE && accept) || (last_fire && (buf_full_q || accept));
  assign src        = buf_full_q ? buf_q : split;
  assign buf_full_d = buf_full_q ? !last_fire : accept && state_q == S_ISSUE && !last_fire;
  assign busy       = state_q == S_ISSUE || buf_full_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      if (accept) buf_q <= split;
    end
  end
`else
  assign in_ready = state_q == S_IDLE;
  assign load     = accept;
  assign src      = split;
  assign busy     = state_q == S_ISSUE;
`endif
  always_comb begin
    state_d     = load ? S_ISSUE : last_fire ? S_IDLE : state_q;
    act_d       = load ? src : act_q;
    {cur_ae, cur_ao, cur_be, cur_bo} = act_d;
    sub_valid_d = load || (sub_valid_q && !last_fire);
    sub_idx_d   = load ? 2'd0 : fire ? sub_idx_q + 2'd1 : sub_idx_q;
    // idx bit 1 selects the A half, bit 0 the B half
    sub_a_d     = (load || fire) ? (sub_idx_d[1] ? cur_ao : cur_ae) : sub_a_q;
    sub_b_d     = (load || fire) ? (sub_idx_d[0] ? cur_bo : cur_be) : sub_b_q;
    sub_last_d  = sub_valid_d && sub_idx_d == IDX_OO;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      act_q       <= '0;
      sub_valid_q <= 1'b0;
      sub_idx_q   <= 2'd0;
      sub_a_q     <= '0;
      sub_b_q     <= '0;
      sub_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      sub_valid_q <= sub_valid_d;
      sub_idx_q   <= sub_idx_d;
      sub_a_q     <= sub_a_d;
      sub_b_q     <= sub_b_d;
      sub_last_q  <= sub_last_d;
    end
  end
  assign sub_valid = sub_valid_q;
  assign sub_idx   = sub_idx_q;
  assign sub_a     = sub_a_q;
  assign sub_b     = sub_b_q;
  assign sub_last  = sub_last_q;
endmodule

// File: tb/tb_obs_split_dispatch_52bit.sv
// tb_obs_split_dispatch_52bit: directed vectors, backpressure, reset, back-to-back and clmul reference checks
module tb_obs_split_dispatch_52bit;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub_ready = 1'b0;
  logic [51:0] a_in = '0, b_in = '0;
  logic in_ready, sub_valid, sub_last, busy;
  logic [25:0] sub_a, sub_b;
  logic [1:0] sub_idx;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  obs_split_dispatch_52bit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .sub_valid(sub_valid), .sub_ready(sub_ready),
    .sub_a(sub_a), .sub_b(sub_b), .sub_idx(sub_idx), .sub_last(sub_last), .busy(busy)
  );
  typedef struct {
    logic [51:0] a, b;
    logic [25:0] ae, ao, be, bo;
  } vec_t;
  vec_t vecs[4];
  logic [25:0] cap_a[4], cap_b[4];
  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", n, got, exp);
  endtask
  task automatic start_op(input logic [51:0] a, input logic [51:0] b);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready before accept", in_ready, 1);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic collect(input string tag);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, " valid"}, sub_valid, 1);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " idx"}, sub_idx, k);
      chk({tag, " last"}, sub_last, k == 3);
      cap_a[k] = sub_a;
      cap_b[k] = sub_b;
    end
  endtask
  function automatic logic [103:0] clmul52(input logic [51:0] a, input logic [51:0] b);
    logic [103:0] r = '0;
    for (int i = 0; i < 52; i++) if (b[i]) r ^= {52'b0, a} << i;
    return r;
  endfunction
  function automatic logic [50:0] clmul26(input logic [25:0] a, input logic [25:0] b);
    logic [50:0] r = '0;
    for (int i = 0; i < 26; i++) if (b[i]) r ^= {25'b0, a} << i;
    return r;
  endfunction
  function automatic logic [103:0] spread(input logic [50:0] p);
    logic [103:0] r = '0;
    for (int i = 0; i < 51; i++) r[2*i] = p[i];
    return r;
  endfunction
  initial begin
    logic [63:0] r;
    logic [51:0] ra, rb;
    logic [103:0] prod;
    logic [25:0] hold_a, hold_b;
    logic [1:0] hold_idx;
    logic stalled;
    int beats, acc_n, last3_c;
    int acc_c[8];
    vecs[0] = '{52'h3, 52'h4, 26'h1, 26'h1, 26'h2, 26'h0};
    vecs[1] = '{52'h5555555555555, 52'h5555555555555, 26'h3FFFFFF, 26'h0, 26'h3FFFFFF, 26'h0};
    vecs[2] = '{52'hAAAAAAAAAAAAA, 52'hFFFFFFFFFFFFF, 26'h0, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF};
    vecs[3] = '{52'h8000000000001, 52'h0000000000002, 26'h1, 26'h2000000, 26'h0, 26'h1};
    #12;
    chk("reset in_ready", in_ready, 1);
    chk("reset sub_valid", sub_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset sub_a/b", {sub_a, sub_b}, 0);
    chk("reset idx/last", {sub_idx, sub_last}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sub_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      start_op(vecs[v].a, vecs[v].b);
      collect("vec beat");
      chk("vec idx0 a", cap_a[0], vecs[v].ae);
      chk("vec idx0 b", cap_b[0], vecs[v].be);
      chk("vec idx1 a", cap_a[1], vecs[v].ae);
      chk("vec idx1 b", cap_b[1], vecs[v].bo);
      chk("vec idx2 a", cap_a[2], vecs[v].ao);
      chk("vec idx2 b", cap_b[2], vecs[v].be);
      chk("vec idx3 a", cap_a[3], vecs[v].ao);
      chk("vec idx3 b", cap_b[3], vecs[v].bo);
      @(negedge clk);
      chk("vec T+5 sub_valid", sub_valid, 0);
      chk("vec T+5 in_ready", in_ready, 1);
      chk("vec T+5 busy", busy, 0);
    end
    start_op(52'h123456789ABCD, 52'hFEDCBA9876543);
    beats = 0;
    stalled = 1'b0;
    hold_a = '0;
    hold_b = '0;
    hold_idx = '0;
    for (int c = 0; c < 30 && beats < 4; c++) begin
      @(negedge clk);
      if (stalled) begin
        chk("stall hold valid", sub_valid, 1);
        chk("stall hold payload", {sub_a, sub_b, sub_idx}, {hold_a, hold_b, hold_idx});
      end
      sub_ready = (c % 4 == 0) || (c % 4 == 3);
      if (sub_valid) begin
        hold_a = sub_a;
        hold_b = sub_b;
        hold_idx = sub_idx;
        stalled = !sub_ready;
        if (sub_ready) begin
          chk("stall beat idx", sub_idx, beats);
          chk("stall beat last", sub_last, beats == 3);
          beats++;
        end
      end
      @(posedge clk);
    end
    chk("stall beat count", beats, 4);
    sub_ready = 1'b1;
    @(negedge clk);
    chk("stall no extra beat", sub_valid, 0);
    start_op(vecs[1].a, vecs[1].b);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst pre idx", sub_idx, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst sub_valid", sub_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst payload", {sub_a, sub_b, sub_idx, sub_last}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(vecs[0].a, vecs[0].b);
    collect("post-rst beat");
    chk("post-rst idx0", {cap_a[0], cap_b[0]}, {26'h1, 26'h2});
    chk("post-rst idx3", {cap_a[3], cap_b[3]}, {26'h1, 26'h0});
    @(negedge clk);
    a_in = vecs[2].a;
    b_in = vecs[2].b;
    in_valid = 1'b1;
    acc_n = 0;
    last3_c = -1;
    for (int c = 0; c < 16; c++) begin
      if (in_ready && acc_n < 8) begin
        acc_c[acc_n] = c;
        acc_n++;
      end
      if (c == last3_c + 1 && last3_c >= 0) begin
`ifdef OBS_SPLIT_PREFETCH_EN
        chk("b2b no bubble", {sub_valid, sub_idx}, 3'b100);
`else
        chk("b2b bubble", sub_valid, 0);
`endif
      end
      if (sub_valid && sub_idx == 2'd3 && last3_c < 0) last3_c = c;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b accepts", acc_n >= 2, 1);
`ifdef OBS_SPLIT_PREFETCH_EN
    chk("b2b spacing", acc_c[1] - acc_c[0], 1);
`else
    chk("b2b spacing", acc_c[1] - acc_c[0], 5);
`endif
    for (int w = 0; w < 40 && busy; w++) @(negedge clk);
    chk("b2b drained", busy, 0);
    for (int t = 0; t < 4; t++) begin
      r = {$urandom(), $urandom()};
      ra = r[51:0];
      r = {$urandom(), $urandom()};
      rb = r[51:0];
      start_op(ra, rb);
      collect("ref beat");
      prod = spread(clmul26(cap_a[0], cap_b[0]))
           ^ (spread(clmul26(cap_a[1], cap_b[1]) ^ clmul26(cap_a[2], cap_b[2])) << 1)
           ^ (spread(clmul26(cap_a[3], cap_b[3])) << 2);
      chk("ref clmul", prod, clmul52(ra, rb));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
